// File: rtl/sync_fifo_gen2_pkg.sv
// Shared types and helpers for the parametrised synchronous FIFO.
// Latency: n/a (compile-time constants, types and functions only).
// Backpressure: n/a.
package sync_fifo_pkg;

    // Read-mode selectors for the FWFT parameter.
    localparam int FWFT_MODE = 1;
    localparam int REG_MODE  = 0;

    // Sticky error flags.
    typedef struct packed {
        logic overflow;
        logic underflow;
    } fifo_err_t;

    // Level/threshold width: must be able to represent 0..DEPTH inclusive.
    function automatic int calc_lvl_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_fifo_gen2_if.sv
// Bundles the FIFO's write, read, threshold and status signals.
// Latency: n/a (wiring only).
// Backpressure: the producer watches o_full; the consumer watches o_rdvalid/o_empty.
// Ports: write side i_wren/i_wrdata, read side i_rden/o_rddata/o_rdvalid,
//        status o_full/o_empty/o_alm_*/o_level/o_peak_level, and the sticky
//        error flags o_overflow/o_underflow with their clear i_clr_err.
// master = producer/consumer side, slave = FIFO side.
interface sync_fifo_gen2_if
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 1024,
    parameter int LVL_W  = calc_lvl_w(DEPTH)
);
    logic              i_wren;
    logic [DATA_W-1:0] i_wrdata;
    logic              i_rden;
    logic [DATA_W-1:0] o_rddata;
    logic              o_rdvalid;
    logic              o_full;
    logic              o_empty;
    logic [LVL_W-1:0]  i_afull_th;
    logic [LVL_W-1:0]  i_aempty_th;
    logic              o_alm_full;
    logic              o_alm_empty;
    logic [LVL_W-1:0]  o_level;
    logic              o_overflow;
    logic              o_underflow;
    logic              i_clr_err;
    logic [LVL_W-1:0]  o_peak_level;

    modport master (
        output i_wren, i_wrdata, i_rden, i_afull_th, i_aempty_th, i_clr_err,
        input  o_rddata, o_rdvalid, o_full, o_empty, o_alm_full, o_alm_empty,
               o_level, o_overflow, o_underflow, o_peak_level
    );

    modport slave (
        input  i_wren, i_wrdata, i_rden, i_afull_th, i_aempty_th, i_clr_err,
        output o_rddata, o_rdvalid, o_full, o_empty, o_alm_full, o_alm_empty,
               o_level, o_overflow, o_underflow, o_peak_level
    );

endinterface

// File: rtl/sync_fifo_gen2_mem.sv
// Storage array: one synchronous write port, one asynchronous read port.
// Latency: write lands on the clock edge; read data follows raddr combinationally.
// Backpressure: none; the control block only issues legal writes.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read). Contents are not reset.
module sync_fifo_mem #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_gen2.sv
// Parametrised single-clock FIFO with FWFT/registered read, thresholds and sticky errors.
// Latency: write-to-visible 1 cycle; FWFT read 0 cycles, registered read 1 cycle.
// Backpressure: writes while full / reads while empty are dropped and flagged.
// Ports: clk, rst (sync, active-low), bus (sync_fifo_gen2_if.slave).
// Optional: define SYNC_FIFO_WATERMARK_EN to build the o_peak_level high-water
// register; otherwise o_peak_level is tied to zero.
module sync_fifo_gen2
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 1024,
    parameter int FWFT   = 1,
    parameter int LVL_W  = calc_lvl_w(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    sync_fifo_gen2_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level;
    logic [LVL_W-1:0]  level_nxt;
    logic [DATA_W-1:0] mem_rdata;
    logic              wr_acc;
    logic              rd_acc;
    fifo_err_t         err;

    // DEPTH need not be a power of two, so wrap by compare.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Status is decoded from the level register only.
    assign bus.o_full      = (level == LVL_W'(DEPTH));
    assign bus.o_empty     = (level == '0);
    assign bus.o_alm_full  = (level >= bus.i_afull_th);
    assign bus.o_alm_empty = (level <= bus.i_aempty_th);
    assign bus.o_level     = level;
    assign bus.o_overflow  = err.overflow;
    assign bus.o_underflow = err.underflow;

    assign wr_acc = bus.i_wren & ~bus.o_full;
    assign rd_acc = bus.i_rden & ~bus.o_empty;

    always_comb begin
        level_nxt = level;
        case ({wr_acc, rd_acc})
            2'b10:   level_nxt = level + 1'b1;
            2'b01:   level_nxt = level - 1'b1;
            default: level_nxt = level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            err    <= '0;
        end else begin
            if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
            level <= level_nxt;
            // A new rejection in the clearing cycle keeps the flag set.
            err.overflow  <= (bus.i_wren & bus.o_full)  | (err.overflow  & ~bus.i_clr_err);
            err.underflow <= (bus.i_rden & bus.o_empty) | (err.underflow & ~bus.i_clr_err);
        end
    end

    sync_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (bus.i_wrdata),
        .raddr (rd_ptr),
        .rdata (mem_rdata)
    );

    generate
        if (FWFT == FWFT_MODE) begin : g_fwft
            assign bus.o_rddata  = mem_rdata;
            assign bus.o_rdvalid = ~bus.o_empty;
        end else begin : g_reg
            logic [DATA_W-1:0] rddata_q;
            logic              rdvalid_q;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    rddata_q  <= '0;
                    rdvalid_q <= 1'b0;
                end else begin
                    rdvalid_q <= rd_acc;
                    if (rd_acc) rddata_q <= mem_rdata;
                end
            end

            assign bus.o_rddata  = rddata_q;
            assign bus.o_rdvalid = rdvalid_q;
        end
    endgenerate

`ifdef SYNC_FIFO_WATERMARK_EN
    logic [LVL_W-1:0] peak_q;

    // Track against the next level so the mark is current with o_level.
    always_ff @(posedge clk) begin
        if (!rst) begin
            peak_q <= '0;
        end else if (bus.i_clr_err) begin
            peak_q <= level_nxt;
        end else if (level_nxt > peak_q) begin
            peak_q <= level_nxt;
        end
    end

    assign bus.o_peak_level = peak_q;
`else
    assign bus.o_peak_level = '0;
`endif

endmodule

// File: doc/sync_fifo_gen2.md
Name: sync_fifo_gen2

Overview:
Parametrised, single-clock successor to the team's 128x1024 synchronous FIFO. Generalised in width and depth, with a compile-time read mode (first-word-fall-through or registered), runtime-programmable almost-full and almost-empty thresholds, a live occupancy count and sticky overflow/underflow error flags. It sits between a streaming producer and consumer in the datapath and is the team's drop-in buffer for new blocks.

Parameters:
DATA_W, 128, data width in bits (>=1)
DEPTH, 1024, number of entries (>=2; need not be a power of two)
FWFT, 1, 1 = first-word-fall-through read; 0 = registered read with one-cycle latency
LVL_W, $clog2(DEPTH+1), width of the level and threshold buses (derived; do not override)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-low reset
i_wren  in  1  write request
i_wrdata  in  DATA_W  write data
i_rden  in  1  read request / pop
o_rddata  out  DATA_W  read data
o_rdvalid  out  1  o_rddata valid qualifier
o_full  out  1  level == DEPTH
o_empty  out  1  level == 0
i_afull_th  in  LVL_W  almost-full threshold
i_aempty_th  in  LVL_W  almost-empty threshold
o_alm_full  out  1  level >= i_afull_th
o_alm_empty  out  1  level <= i_aempty_th
o_level  out  LVL_W  current occupancy
o_overflow  out  1  sticky: write attempted while full
o_underflow  out  1  sticky: read attempted while empty
i_clr_err  in  1  clears the sticky flags and the peak level
o_peak_level  out  LVL_W  high-water mark (optional feature)

Behaviour:
- Reset: one clock, synchronous, active-low. rst low at a clock edge sets wr_ptr = rd_ptr = level = 0, o_overflow = o_underflow = 0, o_rdvalid = 0 and o_rddata = 0 (FWFT=0). Memory array is not reset. Reset asserted mid-operation discards all contents; the first write after reset lands at entry 0.
- Accept rules, evaluated on state at the start of the cycle: wr_acc = i_wren & !o_full; rd_acc = i_rden & !o_empty.
- Pointers increment on accept and wrap from DEPTH-1 to 0 by explicit compare, not by modulo-2^n.
- Level update: +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither.
- Full with i_wren and i_rden together: the read is accepted, the write is rejected and sets o_overflow. Level becomes DEPTH-1.
- Empty with i_wren and i_rden together: the write is accepted, the read is rejected and sets o_underflow. Level becomes 1. There is no bypass.
- o_full, o_empty, o_alm_full, o_alm_empty and o_level are combinational from the level register, so they are valid the cycle after the accept that changes them.
- Thresholds are sampled live. Threshold values greater than DEPTH are legal: o_alm_full never asserts and o_alm_empty always asserts.
- FWFT=1: o_rddata = mem[rd_ptr] combinationally and o_rdvalid = !o_empty. A word written into an empty FIFO is visible on the next cycle. i_rden acts as a pop.
- FWFT=0: on rd_acc, o_rddata is registered with mem[rd_ptr] and o_rdvalid pulses high for exactly the next cycle. Otherwise o_rddata holds its value and o_rdvalid = 0.
- Sticky flags: set on a rejected request; cleared by i_clr_err. When set and clear occur in the same cycle, set wins.

Optional Feature:
SYNC_FIFO_WATERMARK_EN
- Defined: o_peak_level is a register holding the maximum o_level seen since reset or since the last i_clr_err. It is updated each cycle with max(peak, next level). On i_clr_err it loads the next level. Reset value 0.
- Undefined: o_peak_level is tied to 0 and no register is inferred. The port is present in both builds.

Decomposition:
- Package sync_fifo_pkg holds the level-width calculation function, the read-mode localparams FWFT_MODE and REG_MODE, and typedef fifo_err_t (packed struct: overflow, underflow).
- One sub-module, sync_fifo_mem: a simple dual-port array with one write port and an asynchronous-read port, parametrised DATA_W and DEPTH. The control block owns pointers, level, flags and the output register.

Test Plan:
1. DEPTH=16, FWFT=1: reset, then write 0x1..0x10 with no reads -> o_full rises after the 16th accept, o_level=16; a 17th write sets o_overflow=1 and o_level stays 16.
2. Drain the full FIFO from test 1 with one pop per cycle -> data returns 0x1..0x10 in order and o_empty=1; a further pop sets o_underflow=1; i_clr_err clears both flags.
3. DEPTH=5 (not a power of two), FWFT=0: 12 write/read pairs offset by 2 entries -> pointers wrap correctly, each o_rdvalid pulse arrives one cycle after its accepted read, data is in order.
4. Simultaneous i_wren and i_rden at full, then at empty -> at full the level goes 16->15 and overflow sets; at empty the level goes 0->1 and underflow sets.
5. i_afull_th=12, i_aempty_th=3, fill 0->16 -> o_alm_empty deasserts at level 4 and o_alm_full asserts at level 12. Raise i_afull_th to 20 -> o_alm_full drops immediately.
6. With SYNC_FIFO_WATERMARK_EN: fill to 9, drain to 2 -> o_peak_level=9; pulse i_clr_err -> o_peak_level=2. Assert reset mid-burst -> level=0 and peak=0 on the next cycle.
